prelu_pipe: RTL
===============

PRELU_PIPE -- requirements
Module: prelu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: signed sample width.
REQ-002 SHALL have parameter ALPHA_WIDTH, default 8: unsigned alpha width.
REQ-003 SHALL have parameter ALPHA_FRAC, default 7: alpha fractional bits, 1 <= ALPHA_FRAC <= ALPHA_WIDTH.
REQ-004 SHALL have parameter CHANNELS, default 4: number of interleaved channels, >= 1.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port cfg_we, input, 1: alpha write strobe.
REQ-008 SHALL have port cfg_ch, input, $clog2(CHANNELS) (min 1): alpha write channel index.
REQ-009 SHALL have port cfg_alpha, input, ALPHA_WIDTH: alpha write data.
REQ-010 SHALL have port in_valid, input, 1: input beat valid.
REQ-011 SHALL have port in_ready, output, 1: block can accept a beat.
REQ-012 SHALL have port in_data, input, WIDTH signed: sample x.
REQ-013 SHALL have port in_last, input, 1: last beat of a frame.
REQ-014 SHALL have port out_valid, output, 1: output beat valid.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts.
REQ-016 SHALL have port out_data, output, WIDTH signed: result y.
REQ-017 SHALL have port out_ch, output, $clog2(CHANNELS) (min 1): channel of out_data.
REQ-018 SHALL have port out_last, output, 1: in_last delayed with its beat.

Function
REQ-019 Transfer SHALL occur on a cycle with valid and ready both high; data SHALL be held stable while valid is high and ready is low.
REQ-020 y SHALL equal x when x >= 0.
REQ-021 When x < 0: p = x * alpha (signed, WIDTH+ALPHA_WIDTH+1 bits); y SHALL be sat(floor((p + 2^(ALPHA_FRAC-1)) / 2^ALPHA_FRAC)), saturating to [-2^(WIDTH-1), 2^(WIDTH-1)-1] (round half up).
REQ-022 Alpha SHALL come from a CHANNELS-entry register file; cfg_we writes cfg_alpha to entry cfg_ch; cfg_ch >= CHANNELS SHALL be ignored.
REQ-023 A cfg write SHALL take effect for beats accepted on the next cycle or later; a beat accepted on the write cycle SHALL use the old value.
REQ-024 A channel counter SHALL start at 0, tag each accepted beat, and increment per accepted beat, wrapping CHANNELS-1 -> 0.
REQ-025 An accepted beat with in_last=1 SHALL force the counter to 0 for the next beat.
REQ-026 The pipeline SHALL be two register stages: S1 holds x, alpha, ch, last; S2 holds the rounded, saturated y, ch, last.
REQ-027 Latency SHALL be exactly 2 cycles from input accept to out_valid when out_ready is held high.
REQ-028 Throughput SHALL be one beat per cycle with no bubbles while out_ready is high.
REQ-029 Stage advance: S2 loads when S2 is empty or out_ready=1; S1 loads when S1 is empty or S1 advances; in_ready = !S1.valid || (!S2.valid || out_ready).
REQ-030 Under backpressure, no beat SHALL be lost or duplicated, and order SHALL be preserved.

Reset
REQ-031 While reset=0: in_ready=0, out_valid=0, out_data=0, out_ch=0, out_last=0, stage valids=0, channel counter=0.
REQ-032 While reset=0, all alpha entries SHALL be 2^(ALPHA_FRAC-1) (0.5).
REQ-033 Reset mid-stream SHALL discard in-flight beats immediately (asynchronously).
REQ-034 in_ready SHALL rise on the first clk edge after reset deasserts.

Structure
REQ-035 A shared package prelu_pkg SHALL hold the rounding/saturation function and the default-alpha constant.
REQ-036 Sub-module prelu_alpha_rf SHALL implement the alpha register file (write port, one combinational read port).

Verification
REQ-037 Defaults, alpha=64: x=-128,-3,-2,0,127 -> y=-64,-1,-1,0,127, each 2 cycles after accept.
REQ-038 Alpha=255 on ch0: x=-128 -> -128 (saturated); x=-1 -> -2.
REQ-039 CHANNELS=4, alphas 0/64/128/32: ten beats of x=-64, last on beat 6 -> out_ch 0,1,2,3,0,1,0,1,2,3; y=0,-32,-64,-16,0,-32,0,-32,-64,-16.
REQ-040 Random out_ready (50%) over 1000 beats -> output stream matches the reference model in order, with no drops or duplicates.
REQ-041 cfg write to ch0 on the same cycle as a ch0 beat is accepted -> that beat uses the old alpha; the next ch0 beat uses the new alpha.
REQ-042 Reset asserted with 2 beats in flight -> out_valid=0 immediately; after release the counter restarts at ch0 and all alphas read 64.

Source files
------------

// File: rtl/prelu_pkg.sv
// Shared PReLU arithmetic: round-half-up / saturate helper and the reset alpha value.
// Callers sign-extend into the 64-bit accumulator type and truncate the result.
package prelu_pkg;

  localparam int ACC_W = 64;

  // Alpha of 0.5 in a format with `frac` fractional bits.
  function automatic logic [ACC_W-1:0] default_alpha(input int frac);
    return ACC_W'(1) << (frac - 1);
  endfunction

  // floor((p + 2^(frac-1)) / 2^frac), clamped to a signed `width`-bit range.
  function automatic logic signed [ACC_W-1:0] round_sat(
    input logic signed [ACC_W-1:0] p,
    input int                      frac,
    input int                      width
  );
    logic signed [ACC_W-1:0] r;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    r  = (p + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (r > hi) begin
      return hi;
    end
    if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/prelu_alpha_rf.sv
// Per-channel alpha register file: one synchronous write port, one combinational
// read port. Every entry resets to 0.5.
module prelu_alpha_rf
  import prelu_pkg::*;
#(
  parameter int ALPHA_WIDTH = 8,
  parameter int ALPHA_FRAC  = 7,
  parameter int CHANNELS    = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [CW-1:0]          wr_ch,
  input  logic [ALPHA_WIDTH-1:0] wr_alpha,
  input  logic [CW-1:0]          rd_ch,
  output logic [ALPHA_WIDTH-1:0] rd_alpha
);

  localparam logic [ALPHA_WIDTH-1:0] RST_ALPHA = ALPHA_WIDTH'(default_alpha(ALPHA_FRAC));

  logic [ALPHA_WIDTH-1:0] mem [CHANNELS];

  // Out-of-range write indices are dropped rather than aliased.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mem[i] <= RST_ALPHA;
      end
    end else if (we && (int'(wr_ch) < CHANNELS)) begin
      mem[wr_ch] <= wr_alpha;
    end
  end

  assign rd_alpha = (int'(rd_ch) < CHANNELS) ? mem[rd_ch] : '0;

endmodule

// File: rtl/prelu_pipe.sv
// Two-stage PReLU over channel-interleaved samples: S1 captures x and its alpha,
// S2 holds the rounded/saturated result. Full throughput with backpressure.
module prelu_pipe
  import prelu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ALPHA_WIDTH = 8,
  parameter int ALPHA_FRAC  = 7,
  parameter int CHANNELS    = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [CW-1:0]           cfg_ch,
  input  logic [ALPHA_WIDTH-1:0]  cfg_alpha,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [CW-1:0]           out_ch,
  output logic                    out_last
);

  localparam int PW = WIDTH + ALPHA_WIDTH + 1;

  // Handshake: a beat moves on a rising edge where valid && ready; a producer
  // holding valid keeps its data stable until that edge, and ready never waits on valid.

  logic                    rdy_en;
  logic [CW-1:0]           ch_cnt;
  logic [ALPHA_WIDTH-1:0]  rd_alpha;
  logic                    accept;
  logic                    s2_load;

  logic                    s1_valid;
  logic signed [WIDTH-1:0] s1_x;
  logic [ALPHA_WIDTH-1:0]  s1_alpha;
  logic [CW-1:0]           s1_ch;
  logic                    s1_last;

  logic                    s2_valid;
  logic signed [WIDTH-1:0] s2_y;
  logic [CW-1:0]           s2_ch;
  logic                    s2_last;

  logic signed [PW-1:0]    x_ext;
  logic signed [PW-1:0]    a_ext;
  logic signed [PW-1:0]    prod;
  logic signed [WIDTH-1:0] y_next;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = rdy_en && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

  prelu_alpha_rf #(
    .ALPHA_WIDTH (ALPHA_WIDTH),
    .ALPHA_FRAC  (ALPHA_FRAC),
    .CHANNELS    (CHANNELS)
  ) u_alpha_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (cfg_we),
    .wr_ch    (cfg_ch),
    .wr_alpha (cfg_alpha),
    .rd_ch    (ch_cnt),
    .rd_alpha (rd_alpha)
  );

  // Holds in_ready low until the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_cnt <= '0;
    end else if (accept) begin
      if (in_last || (ch_cnt == CW'(CHANNELS - 1))) begin
        ch_cnt <= '0;
      end else begin
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  end

  // Alpha is sampled at accept, so a same-cycle cfg write is seen only by later beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_alpha <= '0;
      s1_ch    <= '0;
      s1_last  <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_x     <= in_data;
      s1_alpha <= rd_alpha;
      s1_ch    <= ch_cnt;
      s1_last  <= in_last;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_comb begin
    x_ext  = PW'(s1_x);
    a_ext  = PW'($signed({1'b0, s1_alpha}));
    prod   = x_ext * a_ext;
    y_next = s1_x;
    if (s1_x[WIDTH-1]) begin
      y_next = WIDTH'(round_sat({{(ACC_W - PW){prod[PW-1]}}, prod}, ALPHA_FRAC, WIDTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_ch    <= '0;
      s2_last  <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y    <= y_next;
        s2_ch   <= s1_ch;
        s2_last <= s1_last;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_y;
  assign out_ch    = s2_ch;
  assign out_last  = s2_last;

endmodule
